// File: rtl/digit_timer_controller.sv
// digit_timer_controller: keypad digit entry, timer load strobes and one-second tick generation
module digit_timer_controller #(
   parameter int TICKS_PER_SEC = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] KeyDigit,
   input  logic       KeyValid,
   input  logic       StartBtn,
   input  logic       FinTIn,
   output logic [3:0] TensBinaryOut,
   output logic [3:0] UnitsBinaryOut,
   output logic       TensInpLoad,
   output logic       UnitsInpLoad,
   output logic       OneSecDec,
   output logic       Running,
   output logic       Done,
   output logic       KeyReject
);
   localparam int PW = $clog2(TICKS_PER_SEC);
   localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

   typedef enum logic [2:0] {IDLE, GOT_TENS, READY, LOAD, RUN, PAUSE, DONE} state_t;

   state_t state, stateNext;
   logic [3:0] tens, units;
   logic [PW-1:0] presc;
   logic firstRun, keyOk, keyBad, zero, capTens, capUnits;

   assign keyOk = KeyValid && (KeyDigit <= 4'd9);
   assign keyBad = KeyValid && (KeyDigit > 4'd9);
   assign zero = (tens == 4'd0) && (units == 4'd0);

   always_comb begin
      stateNext = state;
      capTens = 1'b0;
      capUnits = 1'b0;
      case (state)
         IDLE: if (keyOk) begin
            capTens = 1'b1;
            stateNext = GOT_TENS;
         end
         GOT_TENS: if (keyOk) begin
            capUnits = 1'b1;
            stateNext = READY;
         end
         READY, DONE: if (StartBtn) stateNext = zero ? DONE : LOAD;
         else if (keyOk) begin
            capTens = 1'b1;
            stateNext = GOT_TENS;
         end
         LOAD: stateNext = RUN;
         // the timer is still absorbing the load during the first RUN cycle
         RUN: stateNext = (FinTIn && !firstRun) ? DONE : StartBtn ? PAUSE : RUN;
         PAUSE: stateNext = FinTIn ? DONE : StartBtn ? RUN : PAUSE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         tens <= 4'd0;
         units <= 4'd0;
         presc <= '0;
         firstRun <= 1'b0;
         KeyReject <= 1'b0;
      end else begin
         state <= stateNext;
         tens <= capTens ? KeyDigit : tens;
         units <= capUnits ? KeyDigit : units;
         // count only cycles that stay in RUN so a pause holds the current count
         presc <= (state == LOAD) ? '0 :
                  (state == RUN && stateNext == RUN) ? ((presc == LAST) ? '0 : presc + 1'b1) : presc;
         firstRun <= (state == LOAD);
         KeyReject <= keyBad && (state inside {IDLE, GOT_TENS, READY, DONE});
      end
   end

   assign TensBinaryOut = tens;
   assign UnitsBinaryOut = units;
   assign TensInpLoad = (state == LOAD);
   assign UnitsInpLoad = (state == LOAD);
   assign OneSecDec = (state == RUN) && (presc == LAST);
   assign Running = (state == RUN);
   assign Done = (state == DONE);
endmodule

// File: doc/digit_timer_controller.md
# digit_timer_controller

Front-end control stage that drives the two-digit countdown timer. Accepts keypad digits (tens first, then units), range-checks them, issues the digit values and load strobes to the timer, then generates the once-per-second decrement pulse while running. Supports pause/resume and restart, and stops ticking when the timer reports completion. Sits directly upstream of the two-digit timer; its digit outputs, load strobes and tick pulse connect to the timer's digit inputs, load inputs and one-second-decrement input, and the timer's finish flag returns on FinTIn.

## Interface
- TICKS_PER_SEC, 50000000, clk cycles per OneSecDec pulse; legal values ≥ 2; prescaler width is $clog2(TICKS_PER_SEC)
- clk  in  1  single system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- KeyDigit  in  4  keypad digit value, qualified by KeyValid
- KeyValid  in  1  single-cycle pulse, one per key press (debounced upstream)
- StartBtn  in  1  single-cycle pulse: start / pause / resume / restart
- FinTIn  in  1  timer finished flag (count reached 00)
- TensBinaryOut  out  4  captured tens digit, to timer tens input
- UnitsBinaryOut  out  4  captured units digit, to timer units input
- TensInpLoad  out  1  tens load strobe
- UnitsInpLoad  out  1  units load strobe
- OneSecDec  out  1  one-cycle decrement tick
- Running  out  1  high in RUN
- Done  out  1  high in DONE
- KeyReject  out  1  one-cycle pulse, cycle after an out-of-range digit (KeyDigit > 9)

## Operation
- States: IDLE, GOT_TENS, READY, LOAD, RUN, PAUSE, DONE. Moore outputs, decoded from state, except OneSecDec (state RUN and prescaler == TICKS_PER_SEC-1) and KeyReject (registered).
- Valid digit means KeyValid=1 and KeyDigit ≤ 9.
- KeyDigit > 9 with KeyValid=1 in IDLE, GOT_TENS, READY or DONE: KeyReject pulses. State and digit registers are unchanged.
- IDLE: a valid digit is captured into the tens register, then GOT_TENS. StartBtn is ignored.
- GOT_TENS: a valid digit is captured into the units register, then READY. StartBtn is ignored.
- READY:
  - StartBtn with digits ≠ 00 goes to LOAD.
  - StartBtn with digits 00 goes straight to DONE. No loads and no ticks are issued.
  - A valid digit restarts entry: it becomes the tens digit, then GOT_TENS. The units register holds its old value until overwritten.
- LOAD: exactly one cycle. TensInpLoad and UnitsInpLoad are both high. The prescaler is cleared. Then RUN.
- RUN:
  - The prescaler increments every cycle and wraps from TICKS_PER_SEC-1 to 0. OneSecDec is high in the wrap cycle.
  - StartBtn goes to PAUSE.
  - FinTIn goes to DONE.
  - KeyValid is ignored.
- PAUSE:
  - The prescaler holds its value and no ticks are issued.
  - StartBtn returns to RUN, resuming from the held count.
  - FinTIn goes to DONE.
  - KeyValid is ignored.
- DONE:
  - Done is high.
  - StartBtn goes to LOAD and reloads the held digits (repeat run). With digits 00 it stays in DONE.
  - A valid digit is captured as the tens digit, then GOT_TENS.
- Priority rules:
  - StartBtn beats KeyValid in the same cycle (READY, DONE).
  - FinTIn beats StartBtn in RUN/PAUSE.
  - OneSecDec asserted in the same cycle as a pause/finish transition is still issued.

## Timing
- Reset values (rst high at any edge, any state, including mid-run or mid-load):
  - State IDLE; tens, units and prescaler registers 0.
  - All outputs 0 from the cycle after the reset edge.
- Digit capture: KeyValid in cycle n makes the new digit visible on TensBinaryOut/UnitsBinaryOut in cycle n+1.
- KeyReject: high in cycle n+1 for a bad digit in cycle n.
- Start sequence, StartBtn in cycle n:
  - Load strobes high in cycle n+1 only.
  - RUN begins in cycle n+2 with prescaler 0.
  - First OneSecDec in cycle n+1+TICKS_PER_SEC; subsequent ticks every TICKS_PER_SEC cycles.
- FinTIn handling:
  - Ignored in LOAD and in the first RUN cycle, because the timer is still updating.
  - Sampled from the second RUN cycle on.
  - FinTIn in cycle m gives Done=1 and Running=0 in cycle m+1. No OneSecDec is issued after cycle m.
- Pause: StartBtn in RUN cycle m gives Running=0 in m+1. Resume in cycle p gives the next tick at p+1+(TICKS_PER_SEC-1-held count).
- Digit outputs are stable and change only on capture, so they are valid throughout LOAD.

## Test plan
(All scenarios use TICKS_PER_SEC=4.)
- Reset: assert rst mid-RUN → next cycle all outputs 0, state IDLE; keys 3,7 then StartBtn → Tens=3, Units=7, loads high one cycle.
- Normal run: keys 1,2, StartBtn at cycle 10 → loads at 11, OneSecDec at 15, 19, 23…; FinTIn at 30 → Done=1 at 31, no further ticks.
- Reject/restart: KeyDigit=12 valid → KeyReject pulse, stays IDLE; keys 4,5, then key 6 in READY → Tens=6, GOT_TENS; key 0, StartBtn → loads with 6,0.
- Pause/resume: StartBtn in RUN when prescaler=1 → no tick while paused for 10 cycles; StartBtn resume at p → tick at p+3.
- Zero entry: keys 0,0, StartBtn → Done=1 next cycle, no load, no OneSecDec; StartBtn in DONE → stays DONE.
- Simultaneous events: StartBtn+KeyValid in READY → LOAD, digits unchanged; FinTIn+StartBtn in RUN → DONE; StartBtn in DONE with 2,5 held → LOAD, repeat run.
